fpu_thread_arbiter: RTL and testbench
=====================================

Name: fpu_thread_arbiter

Overview:
Issue arbiter and writeback tag tracker for the shared two-thread FPU. Each cycle it picks one thread to issue an FP op, driving the thread-select into the FPU operand/control mux. It enforces structural hazards for the iterative div/sqrt unit and the single FP writeback port. It tracks thread id, destination and write-enable of in-flight ops so each result is written to the correct thread's FP register file.

Parameters:
LAT, 4, pipelined-op latency (add/sub/mul) in cycles from grant to writeback; legal range 1..8
DIV_CYC, 16, div/sqrt latency in cycles from grant to writeback; must satisfy DIV_CYC > LAT+1; max 63

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req0  in  1  thread 0 has an FP op ready to issue
req1  in  1  thread 1 has an FP op ready to issue
fc0  in  3  thread 0 FP op code: 000 add, 001 sub, 010 mul, 011 div, 100 sqrt, others treated as pipelined
fc1  in  3  thread 1 FP op code, same encoding
fd0  in  5  thread 0 destination FP register
fd1  in  5  thread 1 destination FP register
wf0  in  1  thread 0 op writes the FP register file
wf1  in  1  thread 1 op writes the FP register file
stall  in  1  global FPU stall (freeze)
s  out  1  thread select to the FPU mux (0 = thread 0)
grant0  out  1  thread 0 op issued this cycle
grant1  out  1  thread 1 op issued this cycle
div_busy  out  1  div/sqrt unit occupied (cnt > 1)
wb_we  out  1  FP register write this cycle
wb_tid  out  1  thread of the writeback
wb_fd  out  5  destination register of the writeback

Behaviour:
- State: lg (last-granted thread), s_q (held select), 6-bit cnt (div countdown), div tag {tid, fd, wf}, pipelined tag shift register stages 1..LAT, each {valid, tid, fd, wf}.
- Reset (asynchronous): lg=1, s_q=0, cnt=0, all stage valids=0, div tag=0. Outputs after reset: s=0, grant0/1=0, div_busy=0, wb_we=0, wb_tid=0, wb_fd=0. Reset mid-operation drops all in-flight ops. No writeback is produced for them.
- Eligibility (combinational): threadN is eligible if reqN & ~stall and:
  - for div/sqrt ops (fcN = 011 or 100): cnt <= 1;
  - for all other ops: cnt != LAT+1 (prevents the pipelined result colliding with the div result on the writeback port).
- Arbitration: if both threads are eligible, grant the thread != lg. If one is eligible, grant it. Otherwise no grant. At most one grant per cycle.
- s = granted thread when a grant occurs, else s_q. Grant and s are combinational, same cycle.
- Registered updates on clock edges where stall is low:
  - on a grant, lg and s_q take the granted thread;
  - a pipelined grant enters stage 1 with its tid/fd/wf; stages shift 1→LAT; stage 1 valid=0 if no pipelined grant;
  - a div/sqrt grant loads cnt=DIV_CYC and the div tag;
  - otherwise, if cnt != 0, cnt decrements.
- stall high: no grants, and all state (lg, s_q, cnt, tags) is held.
- Writeback sources:
  - pipelined: stage LAT valid, i.e. cycle t+LAT for a grant in cycle t;
  - div: cnt==1, i.e. cycle t+DIV_CYC.
  - By construction they never coincide. If both do coincide, it is an assertion failure.
- wb_we = (source valid) & wf & ~stall. wb_tid and wb_fd come from the active source; they are 0 when neither is active.
- A div may be granted in the same cycle its predecessor writes back (cnt==1). cnt then reloads.
- div_busy = (cnt > 1).

Test Plan:
- Reset then req0=req1=1, fc=000 both, for 4 cycles. Grants alternate 0,1,0,1 with s=0,1,0,1. wb_we pulses at cycles 4..7 with wb_tid 0,1,0,1 and the matching fd.
- Thread 0 issues div (fc0=011, fd0=3) at cycle 0. Thread 0 requests div again at cycle 2 and is not granted until cycle 16. Thread 1 add requests during that window are granted except at cnt==5. The div writeback at cycle 16 has wb_tid=0, wb_fd=3 and no collision.
- Only req1=1 with mul (fd1=7, wf1=1). grant1 every cycle and lg stays 1. wb_we at t+4 with wb_fd=7. Same stimulus with wf1=0 gives wb_we=0.
- stall=1 for 3 cycles with an add in stage 2. No grants and wb_we=0 during stall. Writeback is delayed by exactly 3 cycles. s holds s_q.
- Assert rst at cycle 5 with a div and two adds in flight. All outputs go to 0 immediately, with no writebacks afterward. First grant after release goes to thread 0 when both request.

Source files
------------

// File: rtl/fpu_thread_arbiter.sv
// rtl/fpu_thread_arbiter.sv - two-thread FPU issue arbiter with writeback tag tracking
module fpu_thread_arbiter #(
  parameter int LAT     = 4,
  parameter int DIV_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] fc0,
  input  logic [2:0] fc1,
  input  logic [4:0] fd0,
  input  logic [4:0] fd1,
  input  logic       wf0,
  input  logic       wf1,
  input  logic       stall,
  output logic       s,
  output logic       grant0,
  output logic       grant1,
  output logic       div_busy,
  output logic       wb_we,
  output logic       wb_tid,
  output logic [4:0] wb_fd
);

  localparam logic [5:0] CNT_BLOCK = 6'(LAT + 1);
  localparam logic [5:0] CNT_LOAD  = 6'(DIV_CYC);

  logic       lg, s_q;
  logic [5:0] cnt;
  logic       div_tid, div_wf;
  logic [4:0] div_fd;
  logic [LAT:1] st_v, st_tid, st_wf;
  logic [4:0]   st_fd [1:LAT];

  logic is_div0, is_div1, elig0, elig1, any, gsel, g_div;
  logic pipe_wb, div_wb, wb_wf;

  assign is_div0 = (fc0 == 3'b011) || (fc0 == 3'b100);
  assign is_div1 = (fc1 == 3'b011) || (fc1 == 3'b100);

  // A pipelined op issued while cnt == LAT+1 would land on the div writeback cycle
  assign elig0 = req0 & ~stall & ~rst & (is_div0 ? (cnt <= 6'd1) : (cnt != CNT_BLOCK));
  assign elig1 = req1 & ~stall & ~rst & (is_div1 ? (cnt <= 6'd1) : (cnt != CNT_BLOCK));

  assign any    = elig0 | elig1;
  assign gsel   = (elig0 & elig1) ? ~lg : elig1;
  assign grant0 = any & ~gsel;
  assign grant1 = any & gsel;
  assign s      = any ? gsel : s_q;
  assign g_div  = gsel ? is_div1 : is_div0;

  assign pipe_wb  = st_v[LAT];
  assign div_wb   = (cnt == 6'd1);
  assign div_busy = (cnt > 6'd1);

  always_comb begin
    wb_tid = 1'b0;
    wb_fd  = 5'd0;
    wb_wf  = 1'b0;
    if (pipe_wb) begin
      wb_tid = st_tid[LAT];
      wb_fd  = st_fd[LAT];
      wb_wf  = st_wf[LAT];
    end else if (div_wb) begin
      wb_tid = div_tid;
      wb_fd  = div_fd;
      wb_wf  = div_wf;
    end
  end

  assign wb_we = (pipe_wb | div_wb) & wb_wf & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lg      <= 1'b1;
      s_q     <= 1'b0;
      cnt     <= 6'd0;
      div_tid <= 1'b0;
      div_fd  <= 5'd0;
      div_wf  <= 1'b0;
      st_v    <= '0;
      st_tid  <= '0;
      st_wf   <= '0;
      for (int i = 1; i <= LAT; i++) st_fd[i] <= 5'd0;
    end else if (!stall) begin
      if (any) begin
        lg  <= gsel;
        s_q <= gsel;
      end
      for (int i = LAT; i > 1; i--) begin
        st_v[i]   <= st_v[i-1];
        st_tid[i] <= st_tid[i-1];
        st_fd[i]  <= st_fd[i-1];
        st_wf[i]  <= st_wf[i-1];
      end
      st_v[1]   <= any & ~g_div;
      st_tid[1] <= gsel;
      st_fd[1]  <= gsel ? fd1 : fd0;
      st_wf[1]  <= gsel ? wf1 : wf0;
      if (any && g_div) begin
        cnt     <= CNT_LOAD;
        div_tid <= gsel;
        div_fd  <= gsel ? fd1 : fd0;
        div_wf  <= gsel ? wf1 : wf0;
      end else if (cnt != 6'd0) begin
        cnt <= cnt - 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(pipe_wb && div_wb));
  end

endmodule

// File: tb/tb_fpu_thread_arbiter.sv
// tb/tb_fpu_thread_arbiter.sv - randomized bench against a cycle-count reference model
module tb_fpu_thread_arbiter;
  localparam int LAT     = 4;
  localparam int DIV_CYC = 16;

  logic       clk = 1'b0, rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, wf0 = 1'b0, wf1 = 1'b0, stall = 1'b0;
  logic [2:0] fc0 = 3'd0, fc1 = 3'd0;
  logic [4:0] fd0 = 5'd0, fd1 = 5'd0;
  logic       s, grant0, grant1, div_busy, wb_we, wb_tid;
  logic [4:0] wb_fd;

  fpu_thread_arbiter #(.LAT(LAT), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .fc0(fc0), .fc1(fc1),
    .fd0(fd0), .fd1(fd1), .wf0(wf0), .wf1(wf1), .stall(stall), .s(s),
    .grant0(grant0), .grant1(grant1), .div_busy(div_busy), .wb_we(wb_we),
    .wb_tid(wb_tid), .wb_fd(wb_fd)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Model time n counts only unstalled cycles; results are scheduled by that time.
  int n, div_at;
  bit m_lg, m_sq;
  int sch_tid [int];
  int sch_fd  [int];
  int sch_wf  [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    div_at = -1;
    m_lg = 1'b1;
    m_sq = 1'b0;
    sch_tid.delete();
    sch_fd.delete();
    sch_wf.delete();
  endtask

  task automatic step(input bit r0, input bit r1, input logic [2:0] f0, input logic [2:0] f1,
                      input logic [4:0] d0, input logic [4:0] d1, input bit w0, input bit w1,
                      input bit st, input bit rs);
    int cnt, key;
    bit dv0, dv1, e0, e1, any, g, gd;
    @(negedge clk);
    req0 = r0; req1 = r1; fc0 = f0; fc1 = f1; fd0 = d0; fd1 = d1;
    wf0 = w0; wf1 = w1; stall = st; rst = rs;
    #1;
    if (rs) begin
      model_reset();
      check("rst_s", 32'(s), 0);
      check("rst_grant0", 32'(grant0), 0);
      check("rst_grant1", 32'(grant1), 0);
      check("rst_div_busy", 32'(div_busy), 0);
      check("rst_wb_we", 32'(wb_we), 0);
      check("rst_wb_tid", 32'(wb_tid), 0);
      check("rst_wb_fd", 32'(wb_fd), 0);
      return;
    end
    cnt = (n <= div_at) ? div_at - n + 1 : 0;
    dv0 = (f0 == 3'd3) || (f0 == 3'd4);
    dv1 = (f1 == 3'd3) || (f1 == 3'd4);
    e0 = r0 && !st && (dv0 ? (cnt <= 1) : (cnt != LAT + 1));
    e1 = r1 && !st && (dv1 ? (cnt <= 1) : (cnt != LAT + 1));
    any = e0 || e1;
    g = (e0 && e1) ? !m_lg : e1;
    check("grant0", 32'(grant0), 32'(any && !g));
    check("grant1", 32'(grant1), 32'(any && g));
    check("s", 32'(s), 32'(any ? g : m_sq));
    check("div_busy", 32'(div_busy), 32'(cnt > 1));
    if (sch_tid.exists(n)) begin
      check("wb_we", 32'(wb_we), 32'(sch_wf[n] != 0 && !st));
      check("wb_tid", 32'(wb_tid), 32'(sch_tid[n]));
      check("wb_fd", 32'(wb_fd), 32'(sch_fd[n]));
    end else begin
      check("wb_we", 32'(wb_we), 0);
      check("wb_tid", 32'(wb_tid), 0);
      check("wb_fd", 32'(wb_fd), 0);
    end
    if (!st) begin
      if (any) begin
        m_lg = g;
        m_sq = g;
        gd = g ? dv1 : dv0;
        key = n + (gd ? DIV_CYC : LAT);
        if (gd) div_at = key;
        sch_tid[key] = int'(g);
        sch_fd[key]  = int'(g ? d1 : d0);
        sch_wf[key]  = int'(g ? w1 : w0);
      end
      sch_tid.delete(n);
      sch_fd.delete(n);
      sch_wf.delete(n);
      n++;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    step(0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    step(1, 1, 3'd0, 3'd0, 5'd0, 5'd0, 0, 0, 0, 1);

    // Both threads add: alternating grants starting with thread 0
    for (int i = 0; i < 4; i++)
      step(1, 1, 3'd0, 3'd0, 5'(2 * i + 1), 5'(2 * i + 2), 1, 1, 0, 0);
    idle(6);

    // Thread 0 div then repeated div requests, thread 1 adds in the shadow
    step(1, 0, 3'd3, 3'd0, 5'd3, 5'd0, 1, 0, 0, 0);
    step(0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step(1, 1, 3'd3, 3'd0, 5'd3, 5'(i), 1, 1, 0, 0);
    idle(20);

    // Thread 1 mul only, with and without register write
    for (int i = 0; i < 8; i++) step(0, 1, 3'd0, 3'd2, 5'd0, 5'd7, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 3'd0, 3'd2, 5'd0, 5'd7, 0, 0, 0, 0);
    idle(6);

    // Stall while an add sits in stage 2
    step(1, 0, 3'd0, 3'd0, 5'd9, 5'd0, 1, 0, 0, 0);
    step(0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 3'd0, 3'd1, 5'd4, 5'd5, 1, 1, 1, 0);
    idle(8);

    // Reset with a div and two adds in flight
    step(1, 0, 3'd4, 3'd0, 5'd11, 5'd0, 1, 0, 0, 0);
    step(0, 1, 3'd0, 3'd0, 5'd0, 5'd12, 0, 1, 0, 0);
    step(1, 0, 3'd0, 3'd0, 5'd13, 5'd0, 1, 0, 0, 0);
    step(0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    step(0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    step(0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    idle(20);
    step(1, 1, 3'd0, 3'd0, 5'd14, 5'd15, 1, 1, 0, 0);
    idle(6);

    for (int i = 0; i < 2500; i++)
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 299) == 0));
    idle(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
